// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - time-multiplexed scan controller for a common-anode seven-segment display
// Holds one hex code per digit and strobes the anodes one slot at a time, with a dead-time gap per slot.
module seg_scan_ctrl #(
  parameter int DIGITS     = 8,
  parameter int SCAN_DIV   = 100000,
  parameter int GAP_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [2:0]        wr_addr,
  input  logic [3:0]        wr_data,
  input  logic [DIGITS-1:0] en_mask,
  input  logic [DIGITS-1:0] dp_mask,
  input  logic              lz_suppress,
  output logic [DIGITS-1:0] an,
  output logic [3:0]        digit_data,
  output logic              dp_n,
  output logic [2:0]        digit_idx
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);
  localparam logic [2:0]    IDX_LAST = 3'(DIGITS - 1);

  typedef enum logic {GAP, SHOW} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [3:0]    dbuf [DIGITS];

  logic              [3:0] cur_code;
  logic                    cur_en;
  logic                    cur_dp;
  logic                    upper_zero;
  logic                    suppressed;
  logic                    visible;
  logic [DIGITS-1:0]       an_next;
  logic                    dp_next;

  // Selection is done by comparison so idx never indexes past a narrow mask.
  always_comb begin
    cur_code   = '0;
    cur_en     = 1'b0;
    cur_dp     = 1'b0;
    upper_zero = 1'b1;
    an_next    = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == 3'(i)) begin
        cur_code = dbuf[i];
        cur_en   = en_mask[i];
        cur_dp   = dp_mask[i];
      end
      if (3'(i) >= idx && dbuf[i] != 4'd0) upper_zero = 1'b0;
    end
    suppressed = lz_suppress && (idx != 3'd0) && upper_zero;
    visible    = cur_en && !suppressed;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == 3'(i) && state == SHOW && visible) an_next[i] = 1'b0;
    end
    dp_next = !(state == SHOW && visible && cur_dp);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= GAP;
      cnt        <= '0;
      idx        <= 3'd0;
      for (int i = 0; i < DIGITS; i++) dbuf[i] <= 4'd0;
      an         <= '1;
      digit_data <= 4'd0;
      dp_n       <= 1'b1;
      digit_idx  <= 3'd0;
    end else begin
      // Out-of-range addresses match no entry and are dropped.
      for (int i = 0; i < DIGITS; i++) begin
        if (wr_en && wr_addr == 3'(i)) dbuf[i] <= wr_data;
      end

      if (cnt == CNT_LAST) begin
        cnt <= '0;
        idx <= (idx == IDX_LAST) ? 3'd0 : idx + 3'd1;
      end else begin
        cnt <= cnt + 1'b1;
      end

      case (state)
        GAP:     if (cnt == GAP_LAST) state <= SHOW;
        SHOW:    if (cnt == CNT_LAST) state <= GAP;
        default: state <= GAP;
      endcase

      an         <= an_next;
      digit_data <= cur_code;
      dp_n       <= dp_next;
      digit_idx  <= idx;
    end
  end

endmodule
